dcache1_wb_queue: RTL and testbench

//  Victim/write-back queue: the receiving end of the dcache1 tag ways' eviction outputs (wb_addr/wb_valid).

---
 rtl/dcache1_wb_queue.sv | 145 ++++++++++++++
 tb/tb_dcache1_wb_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dcache1_wb_queue.sv
// Victim/write-back queue: buffers evicted dcache lines and drains them in order to L2.
// Optional macro DCACHE1_WB_MERGE_EN: inserts hitting a queued non-head entry merge in place.
module dcache1_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 36,
  parameter int unsigned LINE_W = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_en,
  input  logic [ADDR_W:0]          ins_addr,
  input  logic                     ins_valid,
  input  logic [LINE_W-1:0]        ins_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     wb_req,
  output logic [ADDR_W-1:0]        wb_req_addr,
  output logic [LINE_W-1:0]        wb_req_data,
  input  logic                     wb_ack,
  input  logic                     lkp_en,
  input  logic [ADDR_W-1:0]        lkp_addr,
  output logic                     lkp_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              wb_req_q, wb_req_d;
  logic              lkp_hit_q, lkp_hit_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic [LINE_W-1:0] head_data_q, head_data_d;

  logic              ins_try, ins_ok, ack_ok, alloc, merge_hit, data_we, head_wr, any_match;
  logic [PTR_W-1:0]  merge_idx, data_widx;
  logic [ADDR_W-1:0] ins_line;

  // Next-state computation for pointers, occupancy, head register and lookup.
  always_comb begin
    ins_line  = ins_addr[ADDR_W:1];
    ins_try   = ins_en & ins_valid & ins_addr[0];
    ins_ok    = ins_try & ~full_q;
    ack_ok    = wb_ack & wb_req_q;
    merge_hit = 1'b0;
    merge_idx = '0;
`ifdef DCACHE1_WB_MERGE_EN
    // The head may be mid-request, so it is never merged into.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!merge_hit && valid_q[i] && (addr_q[i] == ins_line) && (PTR_W'(i) != rd_ptr_q)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
`endif
    alloc     = ins_ok & ~merge_hit;
    data_we   = ins_ok;
    data_widx = merge_hit ? merge_idx : wr_ptr_q;

    wr_ptr_d = alloc  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = ack_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({alloc, ack_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    valid_d = valid_q;
    if (ack_ok) valid_d[rd_ptr_q] = 1'b0;
    if (alloc)  valid_d[wr_ptr_q] = 1'b1;

    full_d   = (count_d == CNT_W'(DEPTH));
    wb_req_d = (count_d != '0);
    ovf_d    = ovf_q | (ins_try & full_q);

    // Forward this cycle's write if it lands on the next head slot.
    head_wr = ins_ok && (data_widx == rd_ptr_d);
    if (!wb_req_d) begin
      head_addr_d = '0;
      head_data_d = '0;
    end else if (head_wr) begin
      head_addr_d = ins_line;
      head_data_d = ins_data;
    end else begin
      head_addr_d = addr_q[rd_ptr_d];
      head_data_d = data_q[rd_ptr_d];
    end

    any_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lkp_addr)) any_match = 1'b1;
    end
    lkp_hit_d = lkp_en & any_match;
  end

  // Control state, reset synchronously.
  always_ff @(negedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wb_req_q    <= 1'b0;
      lkp_hit_q   <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      wb_req_q    <= wb_req_d;
      lkp_hit_q   <= lkp_hit_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
    end
  end

  // Entry storage; contents are qualified by valid_q so it needs no reset.
  always_ff @(negedge clk) begin
    if (!rst && data_we) begin
      addr_q[data_widx] <= ins_line;
      data_q[data_widx] <= ins_data;
    end
  end

  assign full        = full_q;
  assign count       = count_q;
  assign ovf_err     = ovf_q;
  assign wb_req      = wb_req_q;
  assign wb_req_addr = head_addr_q;
  assign wb_req_data = head_data_q;
  assign lkp_hit     = lkp_hit_q;

endmodule

// File: tb/tb_dcache1_wb_queue.sv
// Scoreboard bench for dcache1_wb_queue (DEPTH=4); follows DCACHE1_WB_MERGE_EN if defined.
module tb_dcache1_wb_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 36;
  localparam int unsigned LINE_W = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ins_en, ins_valid, wb_ack, lkp_en;
  logic [ADDR_W:0]   ins_addr;
  logic [LINE_W-1:0] ins_data;
  logic              full, ovf_err, wb_req, lkp_hit;
  logic [2:0]        count;
  logic [ADDR_W-1:0] wb_req_addr, lkp_addr;
  logic [LINE_W-1:0] wb_req_data;

  ent_t m_q[$];
  logic exp_ovf, exp_hit, exp_rst;
  int   n_checks = 0;
  int   n_err    = 0;

  dcache1_wb_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .ins_en(ins_en), .ins_addr(ins_addr), .ins_valid(ins_valid),
    .ins_data(ins_data), .full(full), .count(count), .ovf_err(ovf_err), .wb_req(wb_req),
    .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data), .wb_ack(wb_ack),
    .lkp_en(lkp_en), .lkp_addr(lkp_addr), .lkp_hit(lkp_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] mkd(input logic [ADDR_W-1:0] a, input logic [31:0] salt);
    return {32{a[31:0] ^ salt}};
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, let the DUT update on negedge, compare on next posedge.
  task automatic cycle(input logic ie, input logic iv, input logic ia0, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic ack, input logic le,
                       input logic [ADDR_W-1:0] la, input logic r);
    logic full_pre, accept, merged;
    rst = r; ins_en = ie; ins_valid = iv; ins_addr = {a, ia0}; ins_data = d;
    wb_ack = ack; lkp_en = le; lkp_addr = la;
    if (r) begin
      m_q.delete();
      exp_ovf = 1'b0;
      exp_hit = 1'b0;
      exp_rst = 1'b1;
    end else begin
      exp_rst = 1'b0;
      exp_hit = 1'b0;
      foreach (m_q[i]) if (le && m_q[i].a == la) exp_hit = 1'b1;
      full_pre = (m_q.size() == DEPTH);
      accept   = ie & iv & ia0;
      merged   = 1'b0;
      if (accept && full_pre) exp_ovf = 1'b1;
`ifdef DCACHE1_WB_MERGE_EN
      if (accept && !full_pre) begin
        for (int i = 1; i < m_q.size(); i++) begin
          if (!merged && m_q[i].a == a) begin
            m_q[i].d = d;
            merged = 1'b1;
          end
        end
      end
`endif
      if (ack && m_q.size() > 0) void'(m_q.pop_front());
      if (accept && !full_pre && !merged) m_q.push_back('{a: a, d: d});
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("count", LINE_W'(count), LINE_W'(m_q.size()));
    chk("full", LINE_W'(full), LINE_W'(m_q.size() == DEPTH));
    chk("wb_req", LINE_W'(wb_req), LINE_W'(m_q.size() != 0));
    chk("ovf_err", LINE_W'(ovf_err), LINE_W'(exp_ovf));
    chk("lkp_hit", LINE_W'(lkp_hit), LINE_W'(exp_hit));
    if (m_q.size() > 0) begin
      chk("head_addr", LINE_W'(wb_req_addr), LINE_W'(m_q[0].a));
      chk("head_data", wb_req_data, m_q[0].d);
    end else if (exp_rst) begin
      chk("rst_addr", LINE_W'(wb_req_addr), '0);
      chk("rst_data", wb_req_data, '0);
    end
  endtask

  task automatic ins(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input logic ack);
    cycle(1'b1, 1'b1, 1'b1, a, d, ack, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, ack, 1'b0, '0, 1'b0);
  endtask

  task automatic lkp(input logic [ADDR_W-1:0] la, input logic ack);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, ack, 1'b1, la, 1'b0);
  endtask

  task automatic reset_cycle(input logic ack);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, ack, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [ADDR_W-1:0] a_, b_, c_;
    exp_ovf = 1'b0; exp_hit = 1'b0; exp_rst = 1'b0;
    reset_cycle(1'b0);

    // Single insert, hold, then ack.
    a_ = 36'h0_0000_1234;
    ins(a_, mkd(a_, 32'h1111_0000), 1'b0);
    for (int k = 0; k < 5; k++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill to full, drop a fifth insert despite a same-cycle ack, drain, then wrap.
    for (int k = 0; k < 4; k++) ins(36'h100 + 36'(k), mkd(36'h100 + 36'(k), 32'h2222_0000), 1'b0);
    ins(36'h1FF, mkd(36'h1FF, 32'h2222_0000), 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    for (int k = 0; k < 6; k++) ins(36'h200 + 36'(k), mkd(36'h200 + 36'(k), 32'h3333_0000), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Undriven or invalid inserts are ignored; insert+ack at count 2 keeps count.
    reset_cycle(1'b0);
    cycle(1'b1, 1'b0, 1'b1, 36'h300, mkd(36'h300, 32'h4444_0000), 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 36'h301, mkd(36'h301, 32'h4444_0000), 1'b0, 1'b0, '0, 1'b0);
    ins(36'h302, mkd(36'h302, 32'h4444_0000), 1'b0);
    ins(36'h303, mkd(36'h303, 32'h4444_0000), 1'b0);
    ins(36'h304, mkd(36'h304, 32'h4444_0000), 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Lookup hits, including the head being acked in the lookup cycle.
    a_ = 36'hA_0000_0400; b_ = 36'hB_0000_0500; c_ = 36'hC_0000_0600;
    ins(a_, mkd(a_, 32'h5555_0000), 1'b0);
    ins(b_, mkd(b_, 32'h5555_0000), 1'b0);
    lkp(a_, 1'b0);
    lkp(c_, 1'b0);
    lkp(a_, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, b_, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, c_, mkd(c_, 32'h5555_0000), 1'b0, 1'b1, c_, 1'b0);
    lkp(c_, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b1);

    // Duplicate insert: merges under the macro, otherwise drains twice.
    ins(a_, mkd(a_, 32'h6666_0000), 1'b0);
    ins(b_, mkd(b_, 32'h6666_0000), 1'b0);
    ins(b_, mkd(b_, 32'h7777_7777), 1'b0);
    ins(a_, mkd(a_, 32'h8888_0000), 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Reset mid-handshake with an ack present.
    for (int k = 0; k < 3; k++) ins(36'h700 + 36'(k), mkd(36'h700 + 36'(k), 32'h9999_0000), 1'b0);
    reset_cycle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
